// File: rtl/aqed_pkg.sv
// aqed_pkg: shared types and helpers for the A-QED pair checker.
//   aqed_state_e : capture progress (IDLE -> ORIG_OUT -> DUP_OUT)
//   DEF_*        : default data / counter widths
//   sat_inc      : saturating increment for counters up to 32 bits wide
package aqed_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ORIG_OUT = 2'd1,
    DUP_OUT  = 2'd2
  } aqed_state_e;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_CNT_W  = 17;

  // Increment v unless it already holds the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/aqed_rb_monitor.sv
// aqed_rb_monitor: response-bound counter with a sticky failure flag.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : clock enable
//   clear_i      : original captured this cycle, restart the count
//   inc_i        : count one accepted input (already enable-qualified)
//   arm_i        : original has been issued
//   done_d_i     : next-state value of the original's output capture
//   bound_i      : response bound in accepted inputs
//   fail_o       : sticky bound violation
module aqed_rb_monitor
  import aqed_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             arm_i,
  input  logic             done_d_i,
  input  logic [CNT_W-1:0] bound_i,
  output logic             fail_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fail_q, fail_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)    cnt_d = '0;
    else if (inc_i) cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    // Compare against the updated count so the flag rises on the same edge
    // the count reaches the bound; an output captured on that edge wins.
    fail_d = fail_q | (en_i & arm_i & ~done_d_i & (cnt_d >= bound_i));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fail_q <= fail_d;
    end
  end

  assign fail_o = fail_q;

endmodule

// File: rtl/aqed_pair_checker.sv
// aqed_pair_checker: A-QED harness between the formal input source and the DUT.
// Forwards the input stream, captures one original transaction, reinserts it
// as a duplicate, matches both outputs by sequence index and reports whether
// they agree. An optional response-bound monitor flags a late original output.
//   clk, reset, clk_en            : clock, async active-high reset, enable
//   bmc_in_data/valid, exec_dup   : free inputs from the formal tool
//   bound_limit                   : response bound (accepted inputs)
//   acc_in_data/valid, acc_in_ready : stream to the DUT
//   acc_out_data/valid            : DUT output stream (no backpressure)
//   orig_issued, orig_done        : original accepted / its output captured
//   qed_done, qed_check           : both outputs captured / outputs equal
//   rb_fail                       : sticky response-bound violation
module aqed_pair_checker
  import aqed_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter bit          CHECK_RB = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] bmc_in_data,
  input  logic              bmc_in_valid,
  input  logic              exec_dup,
  input  logic [CNT_W-1:0]  bound_limit,
  output logic [DATA_W-1:0] acc_in_data,
  output logic              acc_in_valid,
  input  logic              acc_in_ready,
  input  logic [DATA_W-1:0] acc_out_data,
  input  logic              acc_out_valid,
  output logic              orig_issued,
  output logic              orig_done,
  output logic              qed_done,
  output logic              qed_check,
  output logic              rb_fail
);

  aqed_state_e       state_q, state_d;
  logic [CNT_W-1:0]  in_seq_q, in_seq_d;
  logic [CNT_W-1:0]  out_seq_q, out_seq_d;
  logic [CNT_W-1:0]  orig_idx_q, orig_idx_d;
  logic [CNT_W-1:0]  dup_idx_q, dup_idx_d;
  logic [DATA_W-1:0] orig_data_q, orig_data_d;
  logic [DATA_W-1:0] orig_out_q, orig_out_d;
  logic [DATA_W-1:0] dup_out_q, dup_out_d;
  logic              orig_issued_q, orig_issued_d;
  logic              orig_done_q, orig_done_d;
  logic              dup_done_q, dup_done_d;
  logic              qed_done_q, qed_done_d;
  logic              qed_check_q, qed_check_d;

  logic accept, out_ev, in_sat;
  logic cap_orig, cap_dup, orig_hit, dup_hit;
  logic rb_fail_w;

  assign acc_in_valid = bmc_in_valid;
  assign acc_in_data  = (state_q == ORIG_OUT && exec_dup) ? orig_data_q : bmc_in_data;

  assign accept   = acc_in_valid & acc_in_ready & clk_en;
  assign out_ev   = acc_out_valid & clk_en;
  assign in_sat   = &in_seq_q;
  assign cap_orig = accept & exec_dup & (state_q == IDLE) & ~in_sat;
  assign cap_dup  = accept & exec_dup & (state_q == ORIG_OUT) & ~in_sat;

  // An output whose index is being captured on this very edge is matched
  // against in_seq directly, since the index register is not yet written.
  assign orig_hit = out_ev & ~orig_done_q &
                    ((orig_issued_q & (out_seq_q == orig_idx_q)) |
                     (cap_orig & (out_seq_q == in_seq_q)));
  assign dup_hit  = out_ev & ~dup_done_q &
                    (((state_q == DUP_OUT) & (out_seq_q == dup_idx_q)) |
                     (cap_dup & (out_seq_q == in_seq_q)));

  always_comb begin
    state_d       = state_q;
    in_seq_d      = in_seq_q;
    out_seq_d     = out_seq_q;
    orig_idx_d    = orig_idx_q;
    dup_idx_d     = dup_idx_q;
    orig_data_d   = orig_data_q;
    orig_out_d    = orig_out_q;
    dup_out_d     = dup_out_q;
    orig_issued_d = orig_issued_q | cap_orig;
    orig_done_d   = orig_done_q | orig_hit;
    dup_done_d    = dup_done_q | dup_hit;
    qed_done_d    = qed_done_q;
    qed_check_d   = qed_check_q;

    if (accept) in_seq_d  = CNT_W'(sat_inc(32'(in_seq_q), CNT_W));
    if (out_ev) out_seq_d = CNT_W'(sat_inc(32'(out_seq_q), CNT_W));

    unique case (state_q)
      IDLE: if (cap_orig) begin
        orig_idx_d  = in_seq_q;
        orig_data_d = bmc_in_data;
        state_d     = ORIG_OUT;
      end
      ORIG_OUT: if (cap_dup) begin
        dup_idx_d = in_seq_q;
        state_d   = DUP_OUT;
      end
      DUP_OUT: state_d = DUP_OUT;
      default: state_d = IDLE;
    endcase

    if (orig_hit) orig_out_d = acc_out_data;
    if (dup_hit)  dup_out_d  = acc_out_data;

    // Verdict is taken once and then frozen.
    if (clk_en && !qed_done_q && orig_done_q && dup_done_q) begin
      qed_done_d  = 1'b1;
      qed_check_d = (orig_out_q == dup_out_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      in_seq_q      <= '0;
      out_seq_q     <= '0;
      orig_idx_q    <= '0;
      dup_idx_q     <= '0;
      orig_data_q   <= '0;
      orig_out_q    <= '0;
      dup_out_q     <= '0;
      orig_issued_q <= 1'b0;
      orig_done_q   <= 1'b0;
      dup_done_q    <= 1'b0;
      qed_done_q    <= 1'b0;
      qed_check_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_seq_q      <= in_seq_d;
      out_seq_q     <= out_seq_d;
      orig_idx_q    <= orig_idx_d;
      dup_idx_q     <= dup_idx_d;
      orig_data_q   <= orig_data_d;
      orig_out_q    <= orig_out_d;
      dup_out_q     <= dup_out_d;
      orig_issued_q <= orig_issued_d;
      orig_done_q   <= orig_done_d;
      dup_done_q    <= dup_done_d;
      qed_done_q    <= qed_done_d;
      qed_check_q   <= qed_check_d;
    end
  end

  generate
    if (CHECK_RB) begin : g_rb
      aqed_rb_monitor #(
        .CNT_W(CNT_W)
      ) u_rb (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (clk_en),
        .clear_i (cap_orig),
        .inc_i   (accept & orig_issued_q & ~orig_done_q),
        .arm_i   (orig_issued_q),
        .done_d_i(orig_done_d),
        .bound_i (bound_limit),
        .fail_o  (rb_fail_w)
      );
    end else begin : g_no_rb
      assign rb_fail_w = 1'b0;
    end
  endgenerate

  assign orig_issued = orig_issued_q;
  assign orig_done   = orig_done_q;
  assign qed_done    = qed_done_q;
  assign qed_check   = qed_check_q;
  assign rb_fail     = rb_fail_w;

endmodule
